// File: rtl/transpose_ctrl.sv
// Matrix transpose controller: loads ROW_IN rows of COL_IN elements, then drains COL_IN rows of ROW_IN elements.
// Optional feature macro TRANSPOSE_CTRL_DONE_PULSE_EN adds a one-cycle 'done' pulse after the final output row.
module transpose_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_IN     = 4,
    parameter int COL_IN     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COL_IN*DATA_WIDTH-1:0] in_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROW_IN*DATA_WIDTH-1:0] out_row,
    output logic                         out_last,
    output logic                         busy
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
    ,
    output logic                         done
`endif
);

    localparam int RW = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
    localparam int CW = (COL_IN > 1) ? $clog2(COL_IN) : 1;

    typedef enum logic {S_LOAD, S_DRAIN} state_t;

    state_t                r_state;
    logic [RW-1:0]         r_row_cnt;
    logic [CW-1:0]         r_col_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_tile [ROW_IN][COL_IN];

    logic                  w_accept;
    logic                  w_xfer;

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (r_row_cnt == RW'(ROW_IN - 1)) begin
                            r_state     <= S_DRAIN;
                            r_row_cnt   <= '0;
                            r_col_cnt   <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (COL_IN == 1);
                        end else begin
                            r_row_cnt <= r_row_cnt + RW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        if (r_col_cnt == CW'(COL_IN - 1)) begin
                            r_state     <= S_LOAD;
                            r_col_cnt   <= '0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_col_cnt  <= r_col_cnt + CW'(1);
                            r_out_last <= (r_col_cnt == CW'(COL_IN - 2));
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Tile storage carries data only, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < COL_IN; j++) begin
                r_tile[r_row_cnt][j] <= in_row[DATA_WIDTH*j +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        out_row = '0;
        for (int i = 0; i < ROW_IN; i++) begin
            out_row[DATA_WIDTH*i +: DATA_WIDTH] = r_out_valid ? r_tile[i][r_col_cnt] : '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
    assign done = r_done;
`else
    logic w_unused_done;
    assign w_unused_done = r_done;
`endif

endmodule

// File: tb/tb_transpose_ctrl.sv
// Self-checking bench for transpose_ctrl (DATA_WIDTH=8, ROW_IN=4, COL_IN=8) against a matrix-level reference model.
module tb_transpose_ctrl;

    localparam int DW = 8;
    localparam int RI = 4;
    localparam int CI = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [CI*DW-1:0] in_row = '0;
    logic             in_ready;
    logic             out_valid;
    logic [RI*DW-1:0] out_row;
    logic             out_last;
    logic             busy;
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
    logic             done;
`endif

    int checks = 0;
    int failures = 0;

    typedef logic [DW-1:0] mat_t [RI][CI];
    mat_t cur;

    transpose_ctrl #(.DATA_WIDTH(DW), .ROW_IN(RI), .COL_IN(CI)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_row   (in_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_last (out_last),
        .busy     (busy)
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
        ,
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern(input int base);
        for (int i = 0; i < RI; i++)
            for (int j = 0; j < CI; j++)
                cur[i][j] = DW'(base + 8 * i + j);
    endtask

    task automatic fill_random();
        for (int i = 0; i < RI; i++)
            for (int j = 0; j < CI; j++)
                cur[i][j] = DW'($urandom);
    endtask

    // Reference: output row k is column k of the input matrix.
    function automatic logic [RI*DW-1:0] exp_row(input int k);
        logic [RI*DW-1:0] r;
        for (int i = 0; i < RI; i++) r[DW*i +: DW] = cur[i][k];
        return r;
    endfunction

    // mode 0: in_valid always high, 1: toggling 1,0,1,..., 2: random
    task automatic load_matrix(input int mode, output int accepts);
        int r;
        int n;
        logic acc;
        r = 0;
        n = 0;
        accepts = 0;
        while (r < RI && n < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (n % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            for (int j = 0; j < CI; j++) in_row[DW*j +: DW] = cur[r][j];
            acc = in_valid && in_ready;
            cyc();
            n++;
            if (acc) begin
                r++;
                accepts++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_row !== '0) begin failures++; $display("FAIL reset_out_row got=%h exp=0", out_row); end
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
`endif
        rst = 1'b0;
        cyc();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid_rel got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        int acc;
        fill_pattern(0);
        load_matrix(0, acc);
        checks++; if (acc !== RI) begin failures++; $display("FAIL basic_accepts got=%0d exp=%0d", acc, RI); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid got=%b exp=1", out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        checks++; if (out_row !== 32'h18100800) begin failures++; $display("FAIL basic_row0_const got=%h exp=18100800", out_row); end
        out_ready = 1'b1;
        for (int k = 0; k < CI; k++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL basic_row k=%0d got=%h exp=%h", k, out_row, exp_row(k)); end
            checks++; if (out_last !== (k == CI - 1)) begin failures++; $display("FAIL basic_last k=%0d got=%b exp=%b", k, out_last, k == CI - 1); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_drain k=%0d got=%b exp=0", k, in_ready); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_end_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_end_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        int acc;
        int k;
        int n;
        int stall;
        logic xfer;
        fill_pattern(0);
        load_matrix(0, acc);
        k = 0; n = 0; stall = 0;
        while (k < CI && n < 100) begin
            out_ready = !(k == 2 && stall < 3);
            if (!out_ready) stall++;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL bp_row k=%0d got=%h exp=%h", k, out_row, exp_row(k)); end
            checks++; if (out_last !== (k == CI - 1)) begin failures++; $display("FAIL bp_last k=%0d got=%b exp=%b", k, out_last, k == CI - 1); end
            xfer = out_valid && out_ready;
            cyc();
            n++;
            if (xfer) k++;
        end
        out_ready = 1'b0;
        checks++; if (k !== CI) begin failures++; $display("FAIL bp_timeout rows got=%0d exp=%0d", k, CI); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_input_gaps();
        int acc;
        int extra;
        fill_pattern(0);
        load_matrix(1, acc);
        checks++; if (acc !== RI) begin failures++; $display("FAIL gaps_accepts got=%0d exp=%0d", acc, RI); end
        extra = 0;
        out_ready = 1'b1;
        for (int k = 0; k < CI; k++) begin
            in_valid = (k % 2 == 0);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gaps_in_ready k=%0d got=%b exp=0", k, in_ready); end
            checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL gaps_row k=%0d got=%h exp=%h", k, out_row, exp_row(k)); end
            checks++; if (out_last !== (k == CI - 1)) begin failures++; $display("FAIL gaps_last k=%0d got=%b exp=%b", k, out_last, k == CI - 1); end
            if (in_valid && in_ready) extra++;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (extra !== 0) begin failures++; $display("FAIL gaps_drain_accepts got=%0d exp=0", extra); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gaps_end_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_drain();
        int acc;
        int seen;
        fill_pattern(0);
        load_matrix(0, acc);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL mid_row k=%0d got=%h exp=%h", k, out_row, exp_row(k)); end
            cyc();
        end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_async_busy got=%b exp=0", busy); end
        checks++; if (out_row !== '0) begin failures++; $display("FAIL mid_async_row got=%h exp=0", out_row); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rel_in_ready got=%b exp=1", in_ready); end
        seen = 0;
        repeat (4) begin
            if (out_valid !== 1'b0) seen++;
            cyc();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_stray_valid cycles got=%0d exp=0", seen); end
        fill_pattern(100);
        load_matrix(0, acc);
        checks++; if (out_row !== 32'h7C746C64) begin failures++; $display("FAIL mid_fresh_row0 got=%h exp=7c746c64", out_row); end
        for (int k = 0; k < CI; k++) begin
            checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL mid_fresh_row k=%0d got=%h exp=%h", k, out_row, exp_row(k)); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int acc;
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) fill_pattern(0); else fill_random();
            load_matrix(0, acc);
            for (int k = 0; k < CI; k++) begin
                checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL b2b_row m=%0d k=%0d got=%h exp=%h", m, k, out_row, exp_row(k)); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy m=%0d k=%0d got=%b exp=1", m, k, busy); end
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_early m=%0d k=%0d got=%b exp=0", m, k, done); end
`endif
                cyc();
            end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy m=%0d got=%b exp=0", m, busy); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap_in_ready m=%0d got=%b exp=1", m, in_ready); end
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done m=%0d got=%b exp=1", m, done); end
`endif
        end
        cyc();
`ifdef TRANSPOSE_CTRL_DONE_PULSE_EN
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", done); end
`endif
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int acc;
        int k;
        int n;
        logic xfer;
        for (int m = 0; m < 3; m++) begin
            fill_random();
            load_matrix(2, acc);
            checks++; if (acc !== RI) begin failures++; $display("FAIL rnd_accepts m=%0d got=%0d exp=%0d", m, acc, RI); end
            k = 0; n = 0;
            while (k < CI && n < 300) begin
                out_ready = 1'($urandom_range(0, 1));
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rnd_valid m=%0d k=%0d got=%b exp=1", m, k, out_valid); end
                checks++; if (out_row !== exp_row(k)) begin failures++; $display("FAIL rnd_row m=%0d k=%0d got=%h exp=%h", m, k, out_row, exp_row(k)); end
                checks++; if (out_last !== (k == CI - 1)) begin failures++; $display("FAIL rnd_last m=%0d k=%0d got=%b exp=%b", m, k, out_last, k == CI - 1); end
                xfer = out_valid && out_ready;
                cyc();
                n++;
                if (xfer) k++;
            end
            out_ready = 1'b0;
            checks++; if (k !== CI) begin failures++; $display("FAIL rnd_timeout m=%0d rows got=%0d exp=%0d", m, k, CI); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/transpose_ctrl.md
TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: element width in bits.
REQ-002 Parameter ROW_IN, default 4: rows per input matrix, which is also elements per output row.
REQ-003 Parameter COL_IN, default 8: elements per input row, which is also rows per output matrix.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  in_row holds a valid input row.
REQ-008 in_ready  output  1  block accepts in_row this cycle.
REQ-009 in_row  input  COL_IN*DATA_WIDTH  one input row; element j at bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j].
REQ-010 out_valid  output  1  out_row holds a valid transposed row.
REQ-011 out_ready  input  1  downstream accepts out_row this cycle.
REQ-012 out_row  output  ROW_IN*DATA_WIDTH  one transposed row; lane i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-013 out_last  output  1  high with out_valid on output row COL_IN-1.
REQ-014 busy  output  1  high when at least one row of the current matrix is held (row_cnt!=0 or DRAIN).

Function
REQ-015 FSM states: LOAD and DRAIN. Counters: row_cnt (0..ROW_IN-1) and col_cnt (0..COL_IN-1).
REQ-016 Tile buffer: ROW_IN x COL_IN registers of DATA_WIDTH bits.
REQ-017 Input handshake: a row is accepted when in_valid && in_ready.
REQ-018 Load: an accepted row is written to tile row row_cnt, and row_cnt increments.
REQ-019 in_ready = 1 in LOAD and 0 in DRAIN; in_valid gaps stall LOAD with no state change.
REQ-020 LOAD->DRAIN on the accept with row_cnt==ROW_IN-1; row_cnt wraps to 0 and col_cnt is set to 0.
REQ-021 Latency: the last input row is accepted at edge t; out_valid is 1 in the cycle following edge t, presenting output row 0.
REQ-022 out_valid = 1 exactly when in DRAIN.
REQ-023 out_row lane i = tile[i][col_cnt]; out_row is registered or driven from the tile only, with no combinational path from in_row.
REQ-024 An output row transfers when out_valid && out_ready, and col_cnt then increments.
REQ-025 While out_ready=0, out_row, out_last and col_cnt hold unchanged.
REQ-026 DRAIN->LOAD on the transfer with col_cnt==COL_IN-1; in_ready is 1 in the next cycle.
REQ-027 No overlap: the next matrix is never accepted during DRAIN.
REQ-028 Counter widths: clog2 of the respective range, minimum 1 bit; no counter passes its terminal value.
REQ-029 Data passes through unmodified; no arithmetic on element values.

Reset
REQ-030 On rst: state=LOAD, row_cnt=0, col_cnt=0, in_ready=1 after reset release, out_valid=0, out_last=0, busy=0, out_row=0.
REQ-031 Tile contents need no reset; reset mid-LOAD or mid-DRAIN discards the partial matrix and emits no further out_valid.

Configuration
REQ-032 Macro TRANSPOSE_CTRL_DONE_PULSE_EN defined: adds output port done (1 bit, reset 0).
REQ-033 done pulses high for exactly one cycle, in the cycle after the out_row COL_IN-1 transfer.
REQ-034 Macro TRANSPOSE_CTRL_DONE_PULSE_EN undefined: port done does not exist; all other behaviour is identical.

Verification (DATA_WIDTH=8, ROW_IN=4, COL_IN=8; input element(i,j)=8*i+j)
REQ-035 Basic: 4 rows fed back-to-back, out_ready=1 -> out_valid in the cycle after the 4th accept; output row k lanes 0..3 = {k, 8+k, 16+k, 24+k}; out_last only on k=7; then in_ready=1.
REQ-036 Backpressure: out_ready=0 for 3 cycles at k=2 -> out_row stays {2,10,18,26} with out_valid held high; sequence then resumes at k=3 with no loss or duplication.
REQ-037 Input gaps: in_valid toggles 1,0,1,0,... -> only 4 accepts counted; output identical to REQ-035; in_ready=0 throughout DRAIN even with in_valid=1.
REQ-038 Reset mid-DRAIN after k=4: rst pulse -> out_valid=0 and in_ready=1 after release; a fresh matrix with element(i,j)=100+8*i+j yields output row 0 = {100,108,116,124}.
REQ-039 Back-to-back matrices with TRANSPOSE_CTRL_DONE_PULSE_EN defined -> done high for one cycle after each k=7 transfer; second matrix output is correct; busy=0 only between matrices.
